// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID register with stall, EX redirect, J/JAL predecode and syscall halt
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus1,
   output logic        if_id_valid,
   output logic        halted
);
   typedef enum logic {RUN, HALT} state_t;
   state_t state;
   logic [31:0] pc_plus1;
   logic is_jump, is_halt;
   assign pc_plus1 = pc + 32'd1;
   assign is_jump = instr[31:27] == 5'b00001;
   assign is_halt = instr[31:26] == 6'h00 && instr[5:0] == 6'h0C;
   assign halted = state == HALT;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pc <= RESET_PC;
         if_id_instr <= '0;
         if_id_pc_plus1 <= '0;
         if_id_valid <= 1'b0;
      end else if (redirect) begin
         state <= RUN;
         pc <= redirect_pc;
         if_id_instr <= '0;
         if_id_pc_plus1 <= '0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if (state == HALT) begin
            if_id_instr <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid <= 1'b0;
         end else begin
            if_id_instr <= instr;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid <= 1'b1;
            // a syscall parks the PC on itself; jumps resolve here with no delay slot
            pc <= is_halt ? pc : is_jump ? {pc_plus1[31:26], instr[25:0]} : pc_plus1;
            if (is_halt) state <= HALT;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit driven from a bench-owned instruction memory
module tb_fetch_unit;
   logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0, instr, pc, if_id_instr, if_id_pc_plus1;
   logic if_id_valid, halted;
   logic [31:0] mem [512];
   int checks = 0, errors = 0;
   typedef struct {
      logic [31:0] pc, ins, pp1;
      logic v, h;
   } exp_t;
   exp_t q[$];
   logic [31:0] m_pc, m_ins, m_pp1;
   logic m_v, m_h;

   fetch_unit #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .pc(pc), .if_id_instr(if_id_instr),
      .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid), .halted(halted)
   );

   assign instr = mem[pc[8:0]];
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_ins = '0; m_pp1 = '0; m_v = 1'b0; m_h = 1'b0;
   endtask

   task automatic step(input logic s, input logic r, input logic [31:0] rp);
      logic [31:0] w;
      exp_t e;
      stall = s; redirect = r; redirect_pc = rp;
      w = mem[m_pc[8:0]];
      if (r) begin
         m_pc = rp; m_ins = '0; m_pp1 = '0; m_v = 1'b0; m_h = 1'b0;
      end else if (!s) begin
         if (m_h) begin
            m_ins = '0; m_pp1 = '0; m_v = 1'b0;
         end else begin
            m_ins = w; m_pp1 = m_pc + 1; m_v = 1'b1;
            if (w[31:26] == 6'd0 && w[5:0] == 6'd12) m_h = 1'b1;
            else if (w[31:26] == 6'd2 || w[31:26] == 6'd3) m_pc = {m_pp1[31:26], w[25:0]};
            else m_pc = m_pp1;
         end
      end
      q.push_back('{pc: m_pc, ins: m_ins, pp1: m_pp1, v: m_v, h: m_h});
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("pc", pc, e.pc);
      check("if_id_instr", if_id_instr, e.ins);
      check("if_id_pc_plus1", if_id_pc_plus1, e.pp1);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.v});
      check("halted", {31'b0, halted}, {31'b0, e.h});
      stall = 1'b0; redirect = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[4] = 32'h0800_0010;
      mem[6] = 32'h2002_0006;
      mem[9] = 32'h0000_000C;
      mem[9'h33] = 32'h0000_000C;
      mem[9'h40] = 32'h2003_0040;
      model_reset();
      #12;
      check("rst_pc", pc, 32'h0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pp1", if_id_pc_plus1, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b0, 32'h0);
         check("seq_pc", pc, i);
         check("seq_pp1", if_id_pc_plus1, i);
      end
      step(1'b0, 1'b0, 32'h0);
      check("j_pc", pc, 32'h10);
      check("j_instr", if_id_instr, 32'h0800_0010);
      step(1'b0, 1'b0, 32'h0);
      check("j_nobubble", {31'b0, if_id_valid}, 32'h1);
      mem[4] = 32'h0C00_0020;
      step(1'b0, 1'b1, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      check("jal_pc", pc, 32'h20);
      check("jal_pp1", if_id_pc_plus1, 32'h5);
      step(1'b0, 1'b1, 32'h6);
      step(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         check("stall_pc", pc, 32'h7);
         check("stall_instr", if_id_instr, 32'h2002_0006);
      end
      step(1'b0, 1'b0, 32'h0);
      check("unstall_pc", pc, 32'h8);
      step(1'b1, 1'b1, 32'h40);
      check("rds_pc", pc, 32'h40);
      check("rds_valid", {31'b0, if_id_valid}, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("rds_target", if_id_instr, 32'h2003_0040);
      step(1'b0, 1'b1, 32'h9);
      step(1'b1, 1'b0, 32'h0);
      check("stall_halt", {31'b0, halted}, 32'h0);
      step(1'b0, 1'b1, 32'h9);
      check("redir_halt", {31'b0, halted}, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("halt_on", {31'b0, halted}, 32'h1);
      check("halt_instr", if_id_instr, 32'h0000_000C);
      step(1'b0, 1'b0, 32'h0);
      check("halt_pc", pc, 32'h9);
      check("halt_bubble", {31'b0, if_id_valid}, 32'h0);
      step(1'b0, 1'b1, 32'h2);
      check("recover_pc", pc, 32'h2);
      check("recover_halted", {31'b0, halted}, 32'h0);
      step(1'b0, 1'b1, 32'h33);
      step(1'b0, 1'b0, 32'h0);
      check("pre_arst", {31'b0, halted}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("arst_pc", pc, 32'h0);
      check("arst_instr", if_id_instr, 32'h0);
      check("arst_valid", {31'b0, if_id_valid}, 32'h0);
      check("arst_halted", {31'b0, halted}, 32'h0);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
